// File: rtl/ncl_addsub_dr_if.sv
// Dual-rail operand/result bundle for ncl_addsub_dr, with the four-phase completion lines.
// Each data bit is a rail pair {hi,lo}: 01=DATA0, 10=DATA1, 00=NULL, 11=illegal.
interface ncl_addsub_dr_if #(
    parameter int unsigned WIDTH = 4
);
    logic [2*WIDTH-1:0] A;
    logic [2*WIDTH-1:0] B;
    logic [1:0]         carryin;
    logic [1:0]         sub;
    logic               ABCOMP;
    logic               carryinCOMP;
    logic [2*WIDTH-1:0] sum;
    logic               sumCOMP;
    logic [1:0]         carryout;
    logic               carryCOMP;
    logic               err;

    modport slave (
        input  A, B, carryin, sub, sumCOMP, carryCOMP,
        output ABCOMP, carryinCOMP, sum, carryout, err
    );

    modport master (
        output A, B, carryin, sub, sumCOMP, carryCOMP,
        input  ABCOMP, carryinCOMP, sum, carryout, err
    );
endinterface

// File: rtl/ncl_addsub_dr.sv
// Clocked dual-rail NCL adder/subtractor: captures a complete DATA wavefront, holds the
// registered result until both downstream acks arrive, then waits for the input NULL wavefront.
module ncl_addsub_dr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            init,
    ncl_addsub_dr_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] sum_q, sum_d;
    logic [1:0]         cout_q, cout_d;
    logic               comp_q, comp_d;
    logic               err_q, err_d;

    logic               in_complete;
    logic               in_null;
    logic               in_illegal;
    logic [WIDTH-1:0]   a_v;
    logic [WIDTH-1:0]   b_v;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_v;
    logic               sub_v;
    logic [WIDTH:0]     res;
    logic [2*WIDTH-1:0] res_rails;

    // Rail-pair classification and single-rail decode of the incoming wavefront.
    always_comb begin
        in_complete = 1'b1;
        in_null     = 1'b1;
        in_illegal  = 1'b0;
        a_v         = '0;
        b_v         = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            a_v[i]      = bus.A[2*i+1];
            b_v[i]      = bus.B[2*i+1];
            in_complete = in_complete & (bus.A[2*i+1] ^ bus.A[2*i])
                                      & (bus.B[2*i+1] ^ bus.B[2*i]);
            in_null     = in_null & ~(bus.A[2*i+1] | bus.A[2*i])
                                  & ~(bus.B[2*i+1] | bus.B[2*i]);
            in_illegal  = in_illegal | (bus.A[2*i+1] & bus.A[2*i])
                                     | (bus.B[2*i+1] & bus.B[2*i]);
        end
        in_complete = in_complete & (^bus.carryin) & (^bus.sub);
        in_null     = in_null & ~(|bus.carryin) & ~(|bus.sub);
        in_illegal  = in_illegal | (&bus.carryin) | (&bus.sub);
        cin_v       = bus.carryin[1];
        sub_v       = bus.sub[1];
    end

    always_comb begin
        b_eff     = sub_v ? ~b_v : b_v;
        res       = {1'b0, a_v} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_v};
        res_rails = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            res_rails[2*i+1] = res[i];
            res_rails[2*i]   = ~res[i];
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            cout_q  <= '0;
            comp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            comp_q  <= comp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        comp_d  = comp_q;
        err_d   = err_q | in_illegal;
        unique case (state_q)
            EMPTY: begin
                // Downstream acks must have fallen before new DATA goes out.
                if (in_complete && !in_illegal && !bus.sumCOMP && !bus.carryCOMP) begin
                    state_d = HOLD;
                    sum_d   = res_rails;
                    cout_d  = {res[WIDTH], ~res[WIDTH]};
                    comp_d  = 1'b1;
                end
            end
            HOLD: begin
                if (bus.sumCOMP && bus.carryCOMP) begin
                    state_d = RELEASE;
                    sum_d   = '0;
                    cout_d  = '0;
                end
            end
            RELEASE: begin
                if (in_null) begin
                    state_d = EMPTY;
                    comp_d  = 1'b0;
                end
            end
            default: begin
                state_d = EMPTY;
                sum_d   = '0;
                cout_d  = '0;
                comp_d  = 1'b0;
            end
        endcase
    end

    assign bus.sum         = sum_q;
    assign bus.carryout    = cout_q;
    assign bus.ABCOMP      = comp_q;
    assign bus.carryinCOMP = comp_q;
    assign bus.err         = err_q;

endmodule

// File: doc/ncl_addsub_dr.md
Name: ncl_addsub_dr

Overview:
- Parametrised, clocked dual-rail NCL adder/subtractor. Successor to the single-bit two-half-adder full adder cell.
- Accepts WIDTH-bit dual-rail operands, a dual-rail carry-in and a dual-rail add/sub mode bit, all arriving as DATA/NULL wavefronts.
- Produces dual-rail sum and carry-out under a four-phase completion handshake on both sides.
- Sits between NCL pipeline registers wherever a multi-bit ripple adder was previously chained from single-bit cells.

Parameters:
- WIDTH, 4, number of dual-rail operand/sum bits (>=1).

Ports:
- clk  input  1  system clock.
- init  input  1  synchronous active-high reset.
- A  input  2*WIDTH  dual-rail operand A; bit i on {A[2i+1],A[2i]}: 01=DATA0, 10=DATA1, 00=NULL, 11=illegal.
- B  input  2*WIDTH  dual-rail operand B, same encoding.
- carryin  input  2  dual-rail carry-in.
- sub  input  2  dual-rail mode: DATA0=add, DATA1=subtract.
- ABCOMP  output  1  completion to operand/mode source; 1 = DATA captured (send NULL), 0 = ready for DATA.
- carryinCOMP  output  1  completion to carry-in source; same meaning and timing as ABCOMP.
- sum  output  2*WIDTH  dual-rail result, same encoding.
- sumCOMP  input  1  downstream completion for sum.
- carryout  output  2  dual-rail carry-out.
- carryCOMP  input  1  downstream completion for carryout.
- err  output  1  sticky illegal-code flag.

Behaviour:
- Input complete: every pair of A, B, carryin and sub is exactly 01 or 10.
- Input NULL: every such pair is 00.
- Result: add gives A+B+cin; sub gives A+~B+cin. Compute at WIDTH+1 bits; the MSB is carryout.
- Outputs are registered and never show 11. NULL drives all-zero rails.
- Reset (init=1 at edge): state=EMPTY; sum=0, carryout=0, ABCOMP=0, carryinCOMP=0, err=0. Applies from any state, including mid-HOLD or mid-RELEASE; any partial wavefront is discarded.
- EMPTY (outputs NULL, ABCOMP=carryinCOMP=0):
  - Go to HOLD when input complete, sumCOMP=0, carryCOMP=0 and no illegal pair.
  - At that same edge, load the result rails and set ABCOMP=carryinCOMP=1. Latency is 1 clk from the last input rail settling.
  - A partially complete input, or either downstream COMP still 1, means stay and keep waiting.
- HOLD (outputs DATA, ABCOMP=carryinCOMP=1):
  - Go to RELEASE when sumCOMP=1 and carryCOMP=1. Both are required; a single ack holds DATA.
  - At that edge, drive sum/carryout to NULL.
  - Input changes while in HOLD are ignored.
- RELEASE (outputs NULL, ABCOMP=carryinCOMP=1):
  - Go to EMPTY when input NULL; at that edge clear ABCOMP and carryinCOMP.
  - Partially NULL input means stay.
- Downstream COMP falling is checked only by the EMPTY entry condition. This prevents DATA-DATA overrun.
- Illegal code:
  - Any input pair 11 in any state sets err=1 at the next edge. err clears only on init.
  - In EMPTY, an illegal pair blocks the transition. In other states it has no effect beyond err.
- Simultaneous events:
  - init wins over all transitions.
  - An input that becomes complete in the same cycle the downstream COMPs fall is accepted at that edge.
- Wrap-around: sums above 2^WIDTH-1 wrap into sum; the overflow bit appears on carryout. Subtract without borrow gives carryout=DATA1.

Test Plan (WIDTH=4):
- Add: A=0x66 (5), B=0x5A (3), carryin=01, sub=01, COMPs 0 → next edge sum=0x95 (8), carryout=01, ABCOMP=carryinCOMP=1.
- Carry wrap: A=0xAA (F), B=0x56 (1), carryin=01, sub=01 → sum=0x55 (0), carryout=10.
- Subtract: A=0x5A (3), B=0x66 (5), carryin=10, sub=10 → sum=0xA9 (14), carryout=01.
- Handshake:
  - Hold sumCOMP=1 and carryCOMP=0 with a complete input → stays EMPTY and ABCOMP=0; drop sumCOMP → DATA the next edge.
  - In HOLD, raise only sumCOMP → DATA holds; raise carryCOMP → NULL the next edge.
  - Drive inputs partially NULL → ABCOMP stays 1 until all rails are 00.
- Illegal/reset:
  - A[1:0]=11 in EMPTY → err=1 the next edge, no DATA output; err persists after the pair is fixed.
  - init pulse in HOLD → the next edge gives sum=0, carryout=0, ABCOMP=0, err=0, state EMPTY.
